// File: rtl/unit_shop_if.sv
// Player-facing and slot-facing signals of the unit shop.
// master drives buttons, switches, ticks and slot status; slave is the shop itself.
interface unit_shop_if #(
  parameter int NUM_SLOTS = 4,
  parameter int GOLD_W    = 10
);
  logic                 gameTick;
  logic                 buyBtn;
  logic                 SW0;
  logic                 SW1;
  logic                 SW2;
  logic                 SW3;
  logic [NUM_SLOTS-1:0] slotFree;
  logic                 enemyKilled;
  logic [NUM_SLOTS-1:0] purchase;
  logic [3:0]           typeSel;
  logic [GOLD_W-1:0]    gold;
  logic                 reject;
  logic                 busy;

  modport master (
    output gameTick, buyBtn, SW0, SW1, SW2, SW3, slotFree, enemyKilled,
    input  purchase, typeSel, gold, reject, busy
  );

  modport slave (
    input  gameTick, buyBtn, SW0, SW1, SW2, SW3, slotFree, enemyKilled,
    output purchase, typeSel, gold, reject, busy
  );
endinterface

// File: rtl/unit_shop.sv
// Unit shop: gold bank, buy validation, lowest-free-slot grant and tick-based cooldown.
// Purchase pulses two cycles after the button rise; presses outside IDLE are dropped.
module unit_shop #(
  parameter int NUM_SLOTS  = 4,
  parameter int GOLD_W     = 10,
  parameter int GOLD_MAX   = 1023,
  parameter int START_GOLD = 50,
  parameter int INCOME     = 1,
  parameter int BOUNTY     = 5,
  parameter int COST0      = 10,
  parameter int COST1      = 20,
  parameter int COST2      = 40,
  parameter int COST3      = 80,
  parameter int COOLDOWN   = 16
) (
  input  logic        clk,
  input  logic        reset,
  unit_shop_if.slave  shop
);
  localparam int SUM_W = GOLD_W + 2;
  localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_GRANT = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 btn_prev_q;
  logic [3:0]           req_q;
  logic [3:0]           type_q;
  logic [GOLD_W-1:0]    gold_q;
  logic [GOLD_W-1:0]    gold_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 reject_q;

  logic [3:0]           sw;
  logic                 btn_rise;
  logic                 slot_avail;
  logic                 do_grant;
  logic [SUM_W-1:0]     req_cost;
  logic [SUM_W-1:0]     gold_sum;
  logic [NUM_SLOTS-1:0] grant_oh;

  assign sw         = {shop.SW0, shop.SW1, shop.SW2, shop.SW3};
  assign btn_rise   = shop.buyBtn & ~btn_prev_q;
  assign slot_avail = |shop.slotFree;
  assign do_grant   = (state_q == ST_GRANT) && slot_avail;

  // Type bit 3 is SW0, so the cheapest unit sits in the MSB.
  always_comb begin
    req_cost = '0;
    case (req_q)
      4'b1000: req_cost = SUM_W'(COST0);
      4'b0100: req_cost = SUM_W'(COST1);
      4'b0010: req_cost = SUM_W'(COST2);
      4'b0001: req_cost = SUM_W'(COST3);
      default: req_cost = '0;
    endcase
  end

  always_comb begin
    grant_oh = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (shop.slotFree[k]) begin
        grant_oh    = '0;
        grant_oh[k] = 1'b1;
      end
    end
  end

  // All terms are applied together; only the final sum is clamped.
  always_comb begin
    gold_sum = {2'b00, gold_q}
             - (do_grant         ? req_cost         : '0)
             + (shop.gameTick    ? SUM_W'(INCOME)   : '0)
             + (shop.enemyKilled ? SUM_W'(BOUNTY)   : '0);
    gold_d   = (gold_sum > SUM_W'(GOLD_MAX)) ? GOLD_W'(GOLD_MAX) : gold_sum[GOLD_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      btn_prev_q <= 1'b0;
      req_q      <= 4'b0000;
      type_q     <= 4'b0000;
      gold_q     <= GOLD_W'(START_GOLD);
      cnt_q      <= '0;
      reject_q   <= 1'b0;
    end else begin
      btn_prev_q <= shop.buyBtn;
      gold_q     <= gold_d;
      reject_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_rise) begin
            req_q   <= sw;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ($onehot(req_q) && ({2'b00, gold_q} >= req_cost) && slot_avail) begin
            state_q <= ST_GRANT;
          end else begin
            reject_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Slots may have filled since CHECK; an empty set now is a refusal.
          if (slot_avail) begin
            type_q  <= req_q;
            cnt_q   <= CNT_W'(COOLDOWN);
            state_q <= ST_COOL;
          end else begin
            reject_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_COOL: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else if (shop.gameTick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant and type are presented together in the GRANT cycle so a slot samples both at once.
  assign shop.purchase = do_grant ? grant_oh : '0;
  assign shop.typeSel  = do_grant ? req_q : type_q;
  assign shop.gold     = gold_q;
  assign shop.reject   = reject_q;
  assign shop.busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_unit_shop.sv
// Bench for unit_shop: directed scenarios with literal expectations plus random traffic,
// all cycles compared against a transaction-level model of the shop.
module tb_unit_shop;
  logic       clk;
  logic       rst_n;
  logic [3:0] sw_v;
  int         n_checks;
  int         n_errors;

  unit_shop_if #(.NUM_SLOTS(4), .GOLD_W(10)) bus ();

  assign bus.SW0 = sw_v[3];
  assign bus.SW1 = sw_v[2];
  assign bus.SW2 = sw_v[1];
  assign bus.SW3 = sw_v[0];

  unit_shop dut (
    .clk   (clk),
    .reset (rst_n),
    .shop  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_gold;
  bit         m_prev;
  int         m_age;        // cycles since a press was accepted: 1 = being validated, 2 = being granted
  logic [3:0] m_req;
  logic [3:0] m_type;
  bit         m_cool;
  int         m_ticks_left;
  bit         m_rej;

  function automatic int cost_of(logic [3:0] r);
    case (r)
      4'b1000: return 10;
      4'b0100: return 20;
      4'b0010: return 40;
      4'b0001: return 80;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] lowest_free(logic [3:0] s);
    for (int k = 0; k < 4; k++) begin
      if (s[k]) return 4'(1 << k);
    end
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gold = 50; m_prev = 0; m_age = 0; m_req = 0; m_type = 0;
      m_cool = 0; m_ticks_left = 0; m_rej = 0;
    end else begin : mdl
      int ded;
      int g;
      bit rj;
      ded = (m_age == 2 && bus.slotFree != 0) ? cost_of(m_req) : 0;
      g   = m_gold - ded + (bus.gameTick ? 1 : 0) + (bus.enemyKilled ? 5 : 0);
      if (g > 1023) g = 1023;
      rj  = 0;
      if (m_age == 1) begin
        if ($countones(m_req) == 1 && m_gold >= cost_of(m_req) && bus.slotFree != 0) m_age = 2;
        else begin rj = 1; m_age = 0; end
      end else if (m_age == 2) begin
        m_age = 0;
        if (bus.slotFree != 0) begin
          m_type = m_req; m_cool = 1; m_ticks_left = 16;
        end else rj = 1;
      end else if (m_cool) begin
        if (m_ticks_left == 0) m_cool = 0;
        else if (bus.gameTick) m_ticks_left--;
      end else if (bus.buyBtn && !m_prev) begin
        m_req = sw_v; m_age = 1;
      end
      m_prev = bus.buyBtn;
      m_gold = g;
      m_rej  = rj;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [3:0] e_pur;
    logic [3:0] e_typ;
    e_pur = (m_age == 2) ? lowest_free(bus.slotFree) : 4'b0000;
    e_typ = (m_age == 2 && bus.slotFree != 0) ? m_req : m_type;
    check("model_purchase", 32'(bus.purchase), 32'(e_pur));
    check("model_typeSel",  32'(bus.typeSel),  32'(e_typ));
    check("model_gold",     32'(bus.gold),     32'(m_gold));
    check("model_reject",   32'(bus.reject),   32'(m_rej));
    check("model_busy",     32'(bus.busy),     32'(m_age != 0 || m_cool));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(logic [3:0] s, logic [3:0] sf);
    sw_v         = s;
    bus.slotFree = sf;
    bus.buyBtn   = 1'b1;
    step();
    bus.buyBtn   = 1'b0;
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      bus.gameTick = 1'b1;
      step();
      bus.gameTick = 1'b0;
      step();
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    sw_v = 4'b0000;
    bus.gameTick = 1'b0;
    bus.buyBtn = 1'b0;
    bus.slotFree = 4'b0000;
    bus.enemyKilled = 1'b0;
    step();
    step();
    check("rst_gold", 32'(bus.gold), 50);
    check("rst_purchase", 32'(bus.purchase), 0);
    check("rst_typeSel", 32'(bus.typeSel), 0);
    check("rst_reject", 32'(bus.reject), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    step();

    // Basic buy of type 1 into the lowest free slot.
    press(4'b0100, 4'b0110);
    check("buy_busy_check", 32'(bus.busy), 1);
    step();
    check("buy_purchase", 32'(bus.purchase), 32'b0010);
    check("buy_typeSel", 32'(bus.typeSel), 32'b0100);
    step();
    check("buy_pulse_end", 32'(bus.purchase), 0);
    check("buy_gold", 32'(bus.gold), 30);
    check("buy_type_hold", 32'(bus.typeSel), 32'b0100);
    tick_n(15);
    check("cool_busy_15", 32'(bus.busy), 1);
    tick_n(1);
    step();
    check("cool_done", 32'(bus.busy), 0);
    check("cool_gold", 32'(bus.gold), 46);

    // Too expensive.
    press(4'b0001, 4'b1111);
    step();
    check("poor_reject", 32'(bus.reject), 1);
    check("poor_purchase", 32'(bus.purchase), 0);
    step();
    check("poor_reject_end", 32'(bus.reject), 0);
    check("poor_gold", 32'(bus.gold), 46);

    // Two switches at once.
    press(4'b1010, 4'b1111);
    step();
    check("multi_reject", 32'(bus.reject), 1);
    step();
    // No free slot.
    press(4'b1000, 4'b0000);
    step();
    check("noslot_reject", 32'(bus.reject), 1);
    check("noslot_gold", 32'(bus.gold), 46);
    step();

    // Income and bounty in the grant cycle.
    reset_dut();
    press(4'b1000, 4'b1000);
    step();
    check("sim_purchase", 32'(bus.purchase), 32'b1000);
    bus.gameTick = 1'b1;
    bus.enemyKilled = 1'b1;
    step();
    bus.gameTick = 1'b0;
    bus.enemyKilled = 1'b0;
    check("sim_gold", 32'(bus.gold), 46);

    // Press during cooldown is ignored.
    press(4'b0100, 4'b1111);
    step();
    step();
    check("lock_purchase", 32'(bus.purchase), 0);
    check("lock_reject", 32'(bus.reject), 0);
    check("lock_busy", 32'(bus.busy), 1);

    tick_n(1100);
    check("sat_gold", 32'(bus.gold), 1023);
    check("sat_idle", 32'(bus.busy), 0);

    // Reset asserted inside the grant cycle.
    press(4'b0100, 4'b0001);
    step();
    check("rg_purchase", 32'(bus.purchase), 32'b0001);
    #1 rst_n = 1'b0;
    #1;
    check("rg_purchase_drop", 32'(bus.purchase), 0);
    check("rg_gold", 32'(bus.gold), 50);
    check("rg_busy", 32'(bus.busy), 0);
    check("rg_typeSel", 32'(bus.typeSel), 0);
    step();
    rst_n = 1'b1;
    step();
    check("rg_idle", 32'(bus.busy), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.buyBtn = ~bus.buyBtn;
      if ($urandom_range(0, 2) == 0) sw_v = 4'(1 << $urandom_range(0, 3));
      else sw_v = 4'($urandom_range(0, 15));
      bus.slotFree    = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      bus.gameTick    = ($urandom_range(0, 2) == 0);
      bus.enemyKilled = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
